nios_system2_leds: RTL and testbench
====================================

# nios_system2_leds

Avalon-MM output PIO slave driving the board LEDs; the write-side counterpart of the switch input port on the same Nios II system bus. Software writes an output image, with atomic bit-set/bit-clear aliases, and a per-bit blink mask. A free-running prescaler toggles the masked bits in hardware without CPU intervention. All outputs are registered; readback has one-cycle latency.

## Interface
Parameters:
- WIDTH, 18, number of output bits (1..32)
- RESET_VALUE, 0, out_port and DATA value after reset
- BLINK_DIV, 25000000, clocks per blink half-period (≥2); 0.5 s at 50 MHz

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select; qualifies writes only
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH-1 ignored
- readdata  out  32  registered read data, zero-extended
- out_port  out  WIDTH  registered LED drive

## Operation
- Write strobe: chipselect=1 and write_n=0 at a rising edge. There are no wait states. Every strobe completes in one cycle.
- Address 0, DATA (R/W): write loads data_reg ← writedata[WIDTH-1:0]. Read returns data_reg.
- Address 1, BLINK (R/W): write loads blink_reg ← writedata[WIDTH-1:0]. It also forces the prescaler count to 0 and phase to 0. Read returns blink_reg.
- Address 2, SET (W): write performs data_reg ← data_reg | writedata[WIDTH-1:0]. Read returns {31'b0, phase}.
- Address 3, CLEAR (W): write performs data_reg ← data_reg & ~writedata[WIDTH-1:0]. Read returns 0.
- Prescaler:
  - count runs 0..BLINK_DIV-1.
  - At count == BLINK_DIV-1 it wraps to 0 and phase toggles.
  - Counter width is $clog2(BLINK_DIV).
- Output: out_port ← data_reg ^ (blink_reg & {WIDTH{phase}}), evaluated every clock.
- Read path:
  - readdata ← mux(address) every clock, independent of chipselect and write_n (read-side effect free).
  - Unused upper bits are 0.
- Simultaneous events:
  - BLINK write on the same edge as prescaler terminal count: the write wins. Count=0, phase=0, no toggle.
  - Read and write in the same cycle: readdata shows the pre-write value. The new value appears one cycle later.
- Reset (asynchronous, any time, including mid-blink):
  - data_reg=RESET_VALUE, blink_reg=0, count=0, phase=0.
  - out_port=RESET_VALUE, readdata=0.
  - Operation resumes on the first edge after reset_n deasserts.

## Timing
- Write sampled at edge E: the register updates at E, and out_port reflects it at E+1.
- Read: address presented before edge E gives readdata valid after E (1-cycle latency).
- Blink: out_port masked bits toggle every BLINK_DIV clocks (plus 1-cycle output register delay). Full period is 2·BLINK_DIV clocks.
- First toggle after a BLINK write at edge E: phase toggles at edge E+BLINK_DIV, out_port at E+BLINK_DIV+1.

## Structure
- Shared package nios_system2_pio_pkg:
  - Register address constants: PIO_DATA=0, PIO_BLINK=1, PIO_SET=2, PIO_CLEAR=3.
  - PIO_DATA is also used by the switch input port.
- One sub-module, nios_system2_leds_blink_timer:
  - Parameter BLINK_DIV.
  - Inputs: clk, reset_n, restart.
  - Output: phase.
  - Contains the prescaler counter and phase flop.
- Top level holds the register file, read mux and output register.

## Test plan
Bench uses BLINK_DIV=4, WIDTH=18.
- Reset: assert reset_n=0 mid-cycle -> out_port=0 and readdata=0 immediately (asynchronous). Release, then read addr 0 -> 0x00000000.
- DATA write 0xFFFC_0005 at addr 0 -> out_port=0x00005 one edge later. Read addr 0 -> 0x00000005 (upper bits dropped).
- Set/clear:
  - From DATA=0x00005, write SET 0x30000 -> DATA=0x30005.
  - Then write CLEAR 0x00001 -> DATA=0x30004.
  - Read addr 3 -> 0.
- Blink:
  - With DATA=0, write BLINK=0x00003 at edge E.
  - out_port expected: 0x00000 until E+5, 0x00003 from E+5 to E+9, 0x00000 from E+9, repeating.
  - Read addr 2 tracks phase.
- Restart collision: issue a BLINK write exactly on a terminal-count edge -> phase stays 0, no toggle on that edge. The next toggle is 4 clocks later.
- Read/write same cycle: read addr 0 while writing DATA=0x00AAA -> readdata is the old value. The next cycle it is 0x00AAA.

Source files
------------

// File: rtl/nios_system2_pio_pkg.sv
// Register map shared by the Nios II system PIO ports (LED output and switch input).
package nios_system2_pio_pkg;

    localparam logic [1:0] PIO_DATA  = 2'd0;
    localparam logic [1:0] PIO_BLINK = 2'd1;
    localparam logic [1:0] PIO_SET   = 2'd2;
    localparam logic [1:0] PIO_CLEAR = 2'd3;

endpackage

// File: rtl/nios_system2_leds_if.sv
// Avalon-MM slave bus bundle for the PIO ports: zero-wait-state writes, registered reads.
interface nios_system2_leds_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system2_leds_blink_timer.sv
// Free-running blink prescaler: phase toggles every BLINK_DIV clocks; restart zeroes count and phase.
module nios_system2_leds_blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    // A restart takes priority over the terminal count on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CntMax) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/nios_system2_leds.sv
// LED output PIO: DATA register with set/clear aliases, per-bit hardware blink mask,
// registered LED drive and registered one-cycle-latency readback.
module nios_system2_leds
    import nios_system2_pio_pkg::*;
#(
    parameter int unsigned          WIDTH       = 18,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned          BLINK_DIV   = 25000000
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_system2_leds_if.slave  bus,
    output logic [WIDTH-1:0]    out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_q, blink_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             restart;
    logic             phase;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    nios_system2_leds_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        data_d  = data_q;
        blink_d = blink_q;
        restart = 1'b0;
        if (wr_en) begin
            case (bus.address)
                PIO_DATA:  data_d = wdata;
                PIO_BLINK: begin
                    blink_d = wdata;
                    restart = 1'b1;
                end
                PIO_SET:   data_d = data_q | wdata;
                PIO_CLEAR: data_d = data_q & ~wdata;
                default:   data_d = data_q;
            endcase
        end
    end

    // Read mux samples current register state, so a same-cycle write shows up one cycle later.
    always_comb begin
        rdata_d = '0;
        case (bus.address)
            PIO_DATA:  rdata_d = 32'(data_q);
            PIO_BLINK: rdata_d = 32'(blink_q);
            PIO_SET:   rdata_d = {31'b0, phase};
            default:   rdata_d = '0;
        endcase
    end

    assign out_d = data_q ^ (blink_q & {WIDTH{phase}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            blink_q <= '0;
            out_q   <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            blink_q <= blink_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_nios_system2_leds.sv
// Directed self-checking bench for the LED PIO with a short blink divider.
module tb_nios_system2_leds;

    localparam int unsigned WIDTH     = 18;
    localparam int unsigned BLINK_DIV = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    int               n_checks;
    int               n_fail;

    nios_system2_leds_if bus();

    nios_system2_leds #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe lands on the next rising edge; returns 1 ns after that edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(posedge clk);
        #1;
        d = bus.readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            $display("FAIL reset_read_data: got %h want %h", rd, 32'h0);
            n_fail++;
        end
        n_checks++;
        if (out_port !== 18'h0) begin
            $display("FAIL reset_out_port: got %h want %h", out_port, 18'h0);
            n_fail++;
        end
        // Make state non-zero, then drop reset mid-cycle.
        bus_write(2'd0, 32'h0001_5555);
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0001_5555) begin
            $display("FAIL pre_reset_read: got %h want %h", rd, 32'h0001_5555);
            n_fail++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_port !== 18'h0) begin
            $display("FAIL async_reset_out_port: got %h want %h", out_port, 18'h0);
            n_fail++;
        end
        n_checks++;
        if (bus.readdata !== 32'h0) begin
            $display("FAIL async_reset_readdata: got %h want %h", bus.readdata, 32'h0);
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            $display("FAIL reset_read_blink: got %h want %h", rd, 32'h0);
            n_fail++;
        end
    endtask

    task automatic test_data_write;
        logic [31:0] rd;
        bus_write(2'd0, 32'hFFFC_0005);
        n_checks++;
        if (out_port !== 18'h0) begin
            $display("FAIL data_out_same_edge: got %h want %h", out_port, 18'h0);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== 18'h00005) begin
            $display("FAIL data_out_next_edge: got %h want %h", out_port, 18'h00005);
            n_fail++;
        end
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0000_0005) begin
            $display("FAIL data_readback: got %h want %h", rd, 32'h0000_0005);
            n_fail++;
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] rd;
        bus_write(2'd2, 32'h0003_0000);
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0003_0005) begin
            $display("FAIL set_readback: got %h want %h", rd, 32'h0003_0005);
            n_fail++;
        end
        n_checks++;
        if (out_port !== 18'h30005) begin
            $display("FAIL set_out_port: got %h want %h", out_port, 18'h30005);
            n_fail++;
        end
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0003_0004) begin
            $display("FAIL clear_readback: got %h want %h", rd, 32'h0003_0004);
            n_fail++;
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            $display("FAIL clear_addr_read: got %h want %h", rd, 32'h0);
            n_fail++;
        end
    endtask

    // BLINK written at edge E; phase is 1 after edges E+4..E+7, so out_port and the
    // phase readback are 1/3 after edges E+5..E+8, repeating every 8 clocks.
    task automatic test_blink;
        logic [WIDTH-1:0] exp_out;
        logic [31:0]      exp_rd;
        logic [31:0]      rd;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h0000_0003);
        bus.address = 2'd2;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            exp_out = ((((k - 1) / 4) % 2) == 1) ? 18'h00003 : 18'h00000;
            exp_rd  = ((((k - 1) / 4) % 2) == 1) ? 32'h1 : 32'h0;
            n_checks++;
            if (out_port !== exp_out) begin
                $display("FAIL blink_out_k%0d: got %h want %h", k, out_port, exp_out);
                n_fail++;
            end
            n_checks++;
            if (bus.readdata !== exp_rd) begin
                $display("FAIL blink_phase_k%0d: got %h want %h", k, bus.readdata, exp_rd);
                n_fail++;
            end
        end
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0003) begin
            $display("FAIL blink_readback: got %h want %h", rd, 32'h0000_0003);
            n_fail++;
        end
    endtask

    // Entered right after edge E+12 of test_blink, so the next edge (E+13) is not terminal;
    // realign to a terminal-count edge first, then collide a BLINK write with it.
    task automatic test_restart_collision;
        logic [WIDTH-1:0] exp_out;
        logic [31:0]      exp_rd;
        // Count after E+12 is 0; edges E+13, E+14, E+15 bring it to 3; E+16 is terminal.
        repeat (3) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h0000_0003);
        bus.address = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            exp_out = (k == 5) ? 18'h00003 : 18'h00000;
            exp_rd  = (k == 5) ? 32'h1 : 32'h0;
            n_checks++;
            if (out_port !== exp_out) begin
                $display("FAIL restart_out_k%0d: got %h want %h", k, out_port, exp_out);
                n_fail++;
            end
            n_checks++;
            if (bus.readdata !== exp_rd) begin
                $display("FAIL restart_phase_k%0d: got %h want %h", k, bus.readdata, exp_rd);
                n_fail++;
            end
        end
        bus_write(2'd1, 32'h0);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== 18'h0) begin
            $display("FAIL blink_off_out: got %h want %h", out_port, 18'h0);
            n_fail++;
        end
    endtask

    task automatic test_read_write_same_cycle;
        bus_write(2'd0, 32'h0000_0155);
        bus_write(2'd0, 32'h0000_0AAA);
        n_checks++;
        if (bus.readdata !== 32'h0000_0155) begin
            $display("FAIL rw_same_cycle_old: got %h want %h", bus.readdata, 32'h0000_0155);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.readdata !== 32'h0000_0AAA) begin
            $display("FAIL rw_same_cycle_new: got %h want %h", bus.readdata, 32'h0000_0AAA);
            n_fail++;
        end
        n_checks++;
        if (out_port !== 18'h00AAA) begin
            $display("FAIL rw_same_cycle_out: got %h want %h", out_port, 18'h00AAA);
            n_fail++;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        test_reset();
        test_data_write();
        test_set_clear();
        test_blink();
        test_restart_collision();
        test_read_write_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
